mem_arbiter: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Sits between the PC/fetch logic plus the load/store path and a memory with variable acceptance and response latency.
- One transaction outstanding at a time.
- Requests are captured into internal registers, so a requester may move on once granted.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam int BE_W = 4;
  localparam logic [BE_W-1:0] BE_ALL = 4'hF;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and data ports; zero latency.
// Fixed dm priority by default, round-robin on ties when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   win_vld,
  output owner_t win_owner
);

  always_comb begin
    win_vld   = if_req | dm_req;
    win_owner = OWN_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      if (last_owner == OWN_IF) win_owner = OWN_DM;
      else                      win_owner = OWN_IF;
    end else if (dm_req) begin
      win_owner = OWN_DM;
    end
`else
    if (dm_req) win_owner = OWN_DM;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data; gnt same cycle when free,
// mem_req one cycle after capture, stalls on mem_ready. Optional MEM_ARB_RR_EN selects round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  input  logic [BE_W-1:0]  dm_be,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [BE_W-1:0]  mem_be,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err_timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state;
  owner_t           cap_owner;
  logic             cap_we;
  logic [WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  logic [BE_W-1:0]  cap_be;
  logic [CW-1:0]    wd_cnt;

  logic   win_vld;
  owner_t win_owner;
  logic   rsp_hit;
  logic   wd_fire;
  logic   free;
  logic   capture;
  logic   done;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;

  arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .win_vld    (win_vld),
    .win_owner  (win_owner)
  );

  always_ff @(posedge clk) begin
    if (rst)          last_owner <= OWN_IF;
    else if (capture) last_owner <= win_owner;
  end
`else
  arb_pick u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .win_vld   (win_vld),
    .win_owner (win_owner)
  );
`endif

  // A real response always beats the watchdog in the same cycle.
  always_comb begin
    rsp_hit = (state == WAIT) && mem_rvalid;
    wd_fire = (TIMEOUT != 0) && (state == WAIT) && !mem_rvalid && (wd_cnt == CW'(TIMEOUT));
    free    = (state == IDLE) || ((state == ISSUE) && mem_ready && cap_we) || rsp_hit || wd_fire;
    capture = !rst && free && win_vld;
    done    = !rst && (rsp_hit || wd_fire);
  end

  // Gating with rst keeps every handshake quiet during the reset cycle itself.
  always_comb begin
    if_gnt      = capture && (win_owner == OWN_IF);
    dm_gnt      = capture && (win_owner == OWN_DM);
    if_rvalid   = done && (cap_owner == OWN_IF);
    dm_rvalid   = done && (cap_owner == OWN_DM);
    if_rdata    = (if_rvalid && rsp_hit) ? mem_rdata : '0;
    dm_rdata    = (dm_rvalid && rsp_hit) ? mem_rdata : '0;
    err_timeout = !rst && wd_fire;
    mem_req     = !rst && (state == ISSUE);
    mem_we      = cap_we;
    mem_addr    = cap_addr;
    mem_wdata   = cap_wdata;
    mem_be      = cap_be;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_owner <= OWN_IF;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      wd_cnt    <= '0;
    end else if (capture) begin
      state     <= ISSUE;
      cap_owner <= win_owner;
      if (win_owner == OWN_DM) begin
        cap_we    <= dm_we;
        cap_addr  <= dm_addr;
        cap_wdata <= dm_wdata;
        cap_be    <= dm_be;
      end else begin
        cap_we    <= 1'b0;
        cap_addr  <= if_addr;
        cap_wdata <= '0;
        cap_be    <= BE_ALL;
      end
    end else if (free) begin
      state <= IDLE;
    end else if ((state == ISSUE) && mem_ready) begin
      state  <= WAIT;
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed stimulus for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [W-1:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]   dm_be = '0;
  logic         mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic         if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, err_timeout;
  logic [W-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]   mem_be;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: the single outstanding transaction, if any.
  bit           t_vld, t_dm, t_we, t_acc, post_rst, last_dm;
  logic [W-1:0] t_addr, t_wdata;
  logic [3:0]   t_be;
  int           t_waits;
  bit           seen_if_gnt, seen_dm_gnt;

  always @(negedge clk) begin
    bit m_rsp, m_to, m_free, e_dm_gnt, e_if_gnt;
    seen_if_gnt = if_gnt;
    seen_dm_gnt = dm_gnt;
    if (rst) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_err", err_timeout, 0);
      t_vld = 0; last_dm = 0; post_rst = 1;
    end else begin
      m_rsp  = t_vld && t_acc && mem_rvalid;
      m_to   = t_vld && t_acc && !mem_rvalid && (t_waits == TMO);
      m_free = !t_vld || (!t_acc && t_we && mem_ready) || m_rsp || m_to;
      e_dm_gnt = m_free && dm_req && !(if_req && RR_ON && last_dm);
      e_if_gnt = m_free && if_req && !e_dm_gnt;

      chk("dm_gnt", dm_gnt, e_dm_gnt);
      chk("if_gnt", if_gnt, e_if_gnt);
      chk("if_rvalid", if_rvalid, (m_rsp || m_to) && !t_dm);
      chk("dm_rvalid", dm_rvalid, (m_rsp || m_to) && t_dm);
      chk("if_rdata", if_rdata, (m_rsp && !t_dm) ? mem_rdata : '0);
      chk("dm_rdata", dm_rdata, (m_rsp && t_dm) ? mem_rdata : '0);
      chk("err_timeout", err_timeout, m_to);
      chk("mem_req", mem_req, t_vld && !t_acc);
      if (t_vld && !t_acc) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_we", mem_we, t_we);
        chk("mem_be", mem_be, t_be);
        if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
      end else if (post_rst) begin
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
      end

      post_rst = 0;
      if (m_free) t_vld = 0;
      else if (t_vld && !t_acc && mem_ready) begin t_acc = 1; t_waits = 0; end
      else if (t_vld && t_acc) t_waits++;

      if (e_dm_gnt) begin
        t_vld = 1; t_acc = 0; t_dm = 1; t_we = dm_we;
        t_addr = dm_addr; t_wdata = dm_wdata; t_be = dm_be; last_dm = 1;
      end else if (e_if_gnt) begin
        t_vld = 1; t_acc = 0; t_dm = 0; t_we = 0;
        t_addr = if_addr; t_wdata = '0; t_be = 4'hF; last_dm = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    if_req = 0; dm_req = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = $urandom;
    for (int i = 0; i < 8; i++) nxt();
    mem_ready = 0; mem_rvalid = 0;
  endtask

  initial begin
    nxt(); nxt();
    rst = 0;
    nxt();

    // Fetch read with a fixed instruction word.
    if_req = 1; if_addr = 32'h100; nxt();
    if_req = 0; mem_ready = 1; nxt();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093; nxt();
    drain();

    // Tie in idle: dm read first, fetch granted back-to-back on dm's response.
    if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h200; dm_be = 4'hF;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    for (int i = 0; i < 6; i++) begin
      nxt();
      if (seen_dm_gnt) dm_req = 0;
      if (seen_if_gnt) if_req = 0;
    end
    drain();

    // Repeated ties with both ports always requesting.
    if_req = 1; dm_req = 1; dm_we = 0; mem_ready = 1; mem_rvalid = 1;
    for (int i = 0; i < 16; i++) begin
      mem_rdata = $urandom;
      nxt();
      if (seen_dm_gnt) dm_addr = $urandom;
      if (seen_if_gnt) if_addr = $urandom;
    end
    drain();

    // Store held off by memory for three cycles.
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    mem_ready = 0; nxt();
    dm_req = 0; nxt(); nxt(); nxt();
    mem_ready = 1; mem_rvalid = 1; nxt();
    drain();

    // Watchdog: read accepted, memory never answers, then a stray response.
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_ready = 1; mem_rvalid = 0; nxt();
    dm_req = 0;
    for (int i = 0; i < 7; i++) nxt();
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; nxt();
    drain();

    // Reset while waiting for read data.
    if_req = 1; if_addr = 32'h400; mem_ready = 1; mem_rvalid = 0; nxt();
    if_req = 0; nxt();
    nxt();
    rst = 1; nxt();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0; nxt();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h404; nxt();
    if_req = 0;
    drain();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if (!if_req || seen_if_gnt) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end
      if (!dm_req || seen_dm_gnt) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end
      mem_ready  = ($urandom_range(0, 1) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin if_req = 0; dm_req = 0; end
      nxt();
    end
    rst = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
